// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath (slave).
// The opcode and mem_ready signals flow into the sequencer; everything else flows out.
interface mc_control_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_write;
  logic             reg_dst;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op,
           pc_source, state, illegal_op, instr_count
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset sequencer; stalls in FETCH/MEM_READ/MEM_WRITE while mem_ready is low.
// Controls are registered decodes of the next state; only FETCH's ir_write/pc_write follow mem_ready.
module mc_control_fsm #(parameter int CNT_W = 32) (
  input logic              clk,
  input logic              rst,
  mc_control_fsm_if.master bus
);
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE    = 4'd1,  S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,  S_MEM_WB    = 4'd4,  S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,  S_R_WB      = 4'd7,  S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,  S_ADDI_EXEC = 4'd10, S_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR,
      S_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_ADDI_WB:   c.reg_write = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t           state_q, nxt;
  ctl_t             ctl_q, ctl;
  logic [CNT_W-1:0] cnt_q;
  logic             ill_q, retire, bad_op, fetch_go;

  always_comb begin
    nxt    = S_FETCH;
    retire = 1'b0;
    bad_op = 1'b0;
    case (state_q)
      S_FETCH:     nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_R:         nxt = S_R_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EXEC;
          default:      bad_op = 1'b1;
        endcase
      end
      S_MEM_ADDR:  nxt = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: begin
        nxt    = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
        retire = bus.mem_ready;
      end
      S_R_EXEC:    nxt = S_R_WB;
      S_ADDI_EXEC: nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
      default:     nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctl_q   <= decode(S_FETCH);
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= nxt;
      ctl_q   <= decode(nxt);
      if (retire) cnt_q <= cnt_q + 1'b1;
      if (bad_op) ill_q <= 1'b1;
    end
  end

  // Reset must silence every control immediately, not just at the next edge.
  assign ctl      = rst ? '0 : ctl_q;
  assign fetch_go = !rst && (state_q == S_FETCH) && bus.mem_ready;

  assign bus.pc_write      = ctl.pc_write | fetch_go;
  assign bus.ir_write      = fetch_go;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.i_or_d        = ctl.i_or_d;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.alu_op        = ctl.alu_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.state         = state_q;
  assign bus.illegal_op    = ill_q;
  assign bus.instr_count   = cnt_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: per-instruction step lists model the sequencer,
// with directed instruction scenarios pinning latencies, strobes, reset and counter wrap.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(4)) ifc();
  mc_control_fsm #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Model: remaining states of the current instruction, front = current state.
  int   m_seq[$];
  bit   m_legal = 1;
  int   m_cnt = 0;
  bit   m_ill = 0;
  logic [5:0] op_q[$];
  bit   mr_q[$];

  int   trace[$];
  logic [15:0] snap[16];
  int   irw_n;
  bit   any_rw, any_mw;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {ifc.pc_write, ifc.pc_write_cond, ifc.i_or_d, ifc.mem_read, ifc.mem_write,
            ifc.ir_write, ifc.mem_to_reg, ifc.reg_write, ifc.reg_dst, ifc.alu_src_a,
            ifc.alu_src_b, ifc.alu_op, ifc.pc_source};
  endfunction

  // Expected control word per state, in the same bit order as outs().
  function automatic logic [15:0] exp_ctl(input int s, input logic mr);
    logic pcw, pcc, iod, mrd, mwr, irw, m2r, rw, rd, asa;
    logic [1:0] asb, aop, psrc;
    {pcw, pcc, iod, mrd, mwr, irw, m2r, rw, rd, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iod, mrd, mwr, irw, m2r, rw, rd, asa, asb, aop, psrc};
  endfunction

  function automatic int m_state();
    return (m_seq.size() != 0) ? m_seq[0] : 0;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h02 || op == 6'h08;
  endfunction

  task automatic start_instr(input logic [5:0] op);
    m_legal = 1;
    case (op)
      6'h00:   m_seq = '{0, 1, 6, 7};
      6'h23:   m_seq = '{0, 1, 2, 3, 4};
      6'h2B:   m_seq = '{0, 1, 2, 5};
      6'h04:   m_seq = '{0, 1, 8};
      6'h02:   m_seq = '{0, 1, 9};
      6'h08:   m_seq = '{0, 1, 10, 11};
      default: begin m_seq = '{0, 1}; m_legal = 0; end
    endcase
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;
      3: op = 6'h04;  4: op = 6'h02;  5: op = 6'h08;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (is_legal(op)) op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  task automatic drive_next();
    if (m_seq.size() == 0) begin
      ifc.opcode = (op_q.size() != 0) ? op_q.pop_front() : pick_op();
      start_instr(ifc.opcode);
    end
    ifc.mem_ready = (mr_q.size() != 0) ? mr_q.pop_front() : ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_advance();
    int cur;
    if (m_seq.size() == 0) return;
    cur = m_seq[0];
    if ((cur == 0 || cur == 3 || cur == 5) && !ifc.mem_ready) return;
    void'(m_seq.pop_front());
    if (cur == 1 && !m_legal) m_ill = 1;
    if (m_seq.size() == 0 && m_legal) m_cnt = (m_cnt + 1) % 16;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_advance();
    #1;
    drive_next();
  endtask

  // Runs one instruction from FETCH entry back to FETCH, recording what it saw.
  task automatic measure(output int cyc);
    bit left;
    left = 0; cyc = 0; irw_n = 0; any_rw = 0; any_mw = 0;
    trace.delete();
    while (cyc < 60) begin
      @(negedge clk);
      trace.push_back(int'(ifc.state));
      snap[ifc.state] = outs();
      if (ifc.state != 0) left = 1;
      irw_n += int'(ifc.ir_write);
      any_rw |= ifc.reg_write;
      any_mw |= ifc.mem_write;
      cyc++;
      run_cycle();
      if (left && ifc.state == 0) break;
    end
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases after the next-but-one edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_controls", int'(outs()), 0);
    chk("rst_state", int'(ifc.state), 0);
    chk("rst_count", int'(ifc.instr_count), 0);
    chk("rst_illegal", int'(ifc.illegal_op), 0);
    m_seq.delete(); m_cnt = 0; m_ill = 0; m_legal = 1;
    op_q.delete(); mr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("state", int'(ifc.state), m_state());
      chk("controls", int'(outs()), int'(exp_ctl(m_state(), ifc.mem_ready)));
      chk("count", int'(ifc.instr_count), m_cnt);
      chk("illegal", int'(ifc.illegal_op), int'(m_ill));
    end
  end

  initial begin
    int c, sum;
    ifc.opcode = 6'h00;
    ifc.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    op_q = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h00};
    mr_q = '{1,1,1,1,  0,0,1,1,1,0,0,0,1,1,  1,1,1,1, 1,1,1, 1,1,1, 1,1,1,1,  1,1,  1,1,1,1};
    drive_next();

    measure(c);
    chk("rtype_cycles", c, 4);
    chk("rtype_len", trace.size(), 4);
    if (trace.size() == 4) begin
      chk("rtype_s0", trace[0], 0); chk("rtype_s1", trace[1], 1);
      chk("rtype_s2", trace[2], 6); chk("rtype_s3", trace[3], 7);
    end
    chk("rtype_end_state", int'(ifc.state), 0);
    chk("rwb_rw_rd", int'(snap[7][8:7]), 3);
    chk("rtype_count", int'(ifc.instr_count), 1);

    measure(c);
    chk("lw_cycles", c, 10);
    chk("lw_irw_pulses", irw_n, 1);
    chk("memwb_m2r", int'(snap[4][9]), 1);
    chk("lw_count", int'(ifc.instr_count), 2);

    sum = 0;
    measure(c); chk("sw_cycles", c, 4); sum += c;
    measure(c); chk("beq_cycles", c, 3); sum += c;
    chk("branch_aluop_pcsrc", int'(snap[8][3:0]), 4'b0101);
    measure(c); chk("j_cycles", c, 3); sum += c;
    chk("jump_pcsrc", int'(snap[9][1:0]), 2);
    measure(c); chk("addi_cycles", c, 4); sum += c;
    chk("b2b_cycles", sum, 14);
    chk("b2b_count", int'(ifc.instr_count), 6);

    measure(c);
    chk("illegal_cycles", c, 2);
    chk("illegal_flag", int'(ifc.illegal_op), 1);
    chk("illegal_no_write", int'({any_rw, any_mw}), 0);
    chk("illegal_count", int'(ifc.instr_count), 6);
    measure(c);
    chk("post_illegal_cycles", c, 4);
    chk("post_illegal_count", int'(ifc.instr_count), 7);

    do_reset();
    op_q = '{6'h23};
    mr_q = '{1, 1, 1, 0, 0, 0, 0, 0};
    drive_next();
    for (int i = 0; i < 10 && ifc.state != 3; i++) run_cycle();
    chk("reach_mem_read", int'(ifc.state), 3);
    chk("mem_read_active", int'(ifc.mem_read), 1);
    do_reset();

    for (int i = 0; i < 17; i++) op_q.push_back(6'h02);
    drive_next();
    for (int i = 0; i < 17; i++) measure(c);
    chk("wrap_count", int'(ifc.instr_count), 1);

    for (int r = 0; r < 3; r++) begin
      repeat (600) run_cycle();
      do_reset();
      drive_next();
    end
    repeat (50) run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
